// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU sequencer and the ALU it drives.
package alu_seq_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int RF_DEPTH       = 8;

  // ALU op codes, shared with the ALU itself.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;
  localparam logic [2:0] ALU_PSA = 3'b111;

  // Host command word: [11:9] op, [8:6] rd, [5:3] ra, [2:0] rb.
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_EXEC  = 2'b10
  } state_e;

endpackage

// File: rtl/alu_sequencer_cmd_fifo.sv
// Small synchronous command FIFO. A push is refused while full, even if a
// pop happens in the same cycle; the head entry is visible combinationally.
module cmd_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];

  // Storage array: written at the tail on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: buffers host commands, owns an 8-entry register file and
// drives the shared ALU with registered operands, two cycles per command.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       cmd,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              run,
  input  logic              reg_we,
  input  logic [2:0]        reg_waddr,
  input  logic [DATA_W-1:0] reg_wdata,
  input  logic [2:0]        reg_raddr,
  output logic [DATA_W-1:0] reg_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_o,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_n,
  output logic [DATA_W-1:0] result,
  output logic              flag_o,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_n,
  output logic              busy,
  output logic              done
);

  state_e            r_state;
  logic [DATA_W-1:0] r_rf [RF_DEPTH];
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [2:0]        r_alu_op;
  logic [2:0]        r_rd;
  logic [DATA_W-1:0] r_result;
  logic [3:0]        r_flags;
  logic              r_busy;
  logic              r_done;

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_more;
  logic [11:0]       w_head_raw;
  cmd_t              w_head;

  assign w_push    = cmd_valid && !w_fifo_full;
  assign w_pop     = (r_state == ST_ISSUE);
  // A command arriving on the write-back edge still belongs to this run.
  assign w_more    = !w_fifo_empty || w_push;
  assign w_head    = cmd_t'(w_head_raw);

  assign cmd_ready = !w_fifo_full;
  assign reg_rdata = r_rf[reg_raddr];
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign result    = r_result;
  assign flag_o    = r_flags[3];
  assign flag_c    = r_flags[2];
  assign flag_z    = r_flags[1];
  assign flag_n    = r_flags[0];
  assign busy      = r_busy;
  assign done      = r_done;

  cmd_fifo #(
    .WIDTH (12),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (cmd),
    .i_pop   (w_pop),
    .o_rdata (w_head_raw),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Sequencer FSM with register file, operand, result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= 3'b000;
      r_rd     <= 3'b000;
      r_result <= '0;
      r_flags  <= 4'b0000;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      for (int i = 0; i < RF_DEPTH; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Host writes land only here; a same-cycle run still starts.
          if (reg_we) begin
            r_rf[reg_waddr] <= reg_wdata;
          end
          if (run && !w_fifo_empty) begin
            r_state <= ST_ISSUE;
            r_busy  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          r_alu_op <= w_head.op;
          r_alu_a  <= r_rf[w_head.ra];
          r_alu_b  <= r_rf[w_head.rb];
          r_rd     <= w_head.rd;
          r_state  <= ST_EXEC;
        end
        ST_EXEC: begin
          r_rf[r_rd] <= alu_y;
          r_result   <= alu_y;
          r_flags    <= {alu_o, alu_c, alu_z, alu_n};
          if (w_more) begin
            r_state <= ST_ISSUE;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: models the ALU, keeps a register
// file model and a scoreboard of expected write-backs.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [11:0]   cmd;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          run;
  logic          reg_we;
  logic [2:0]    reg_waddr;
  logic [DW-1:0] reg_wdata;
  logic [2:0]    reg_raddr;
  logic [DW-1:0] reg_rdata;
  logic [DW-1:0] alu_a, alu_b, alu_y, result;
  logic [2:0]    alu_op;
  logic          alu_o, alu_c, alu_z, alu_n;
  logic          flag_o, flag_c, flag_z, flag_n;
  logic          busy, done;

  alu_sequencer #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .run(run), .reg_we(reg_we),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_raddr(reg_raddr),
    .reg_rdata(reg_rdata), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_o(alu_o), .alu_c(alu_c), .alu_z(alu_z),
    .alu_n(alu_n), .result(result), .flag_o(flag_o), .flag_c(flag_c),
    .flag_z(flag_z), .flag_n(flag_n), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] y;
    logic [3:0]    f;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] m_rf [8];
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            wb_cnt = 0;
  int            t_issue = 0;
  int            t_done = 0;
  bit            in_exec = 1'b0;
  bit            wb_due = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference ALU: returns {o, c, z, n, y}.
  function automatic logic [35:0] alu_model(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [32:0]   t;
    logic [DW-1:0] y;
    logic          o, c;
    t = '0; y = '0; o = 1'b0; c = 1'b0;
    case (op)
      ALU_ADD: begin
        t = {1'b0, a} + {1'b0, b}; y = t[31:0]; c = t[32];
        o = (a[31] == b[31]) && (y[31] != a[31]);
      end
      ALU_SUB: begin
        t = {1'b0, a} - {1'b0, b}; y = t[31:0]; c = t[32];
        o = (a[31] != b[31]) && (y[31] != a[31]);
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SHL: y = a << b[4:0];
      ALU_SHR: y = a >> b[4:0];
      default: y = a;
    endcase
    return {o, c, (y == 32'd0), y[31], y};
  endfunction

  always_comb begin
    {alu_o, alu_c, alu_z, alu_n, alu_y} = alu_model(alu_op, alu_a, alu_b);
  end

  always @(posedge clk) cyc++;

  // Monitor: follows ISSUE/EXEC phases from busy, checks operands in EXEC
  // and the written-back result/flags one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_exec = 1'b0;
      wb_due  = 1'b0;
    end else begin
      if (wb_due) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("wb_result", result, e.y);
          check_eq("wb_flags", {flag_o, flag_c, flag_z, flag_n}, e.f);
        end
        wb_cnt++;
      end
      wb_due = 1'b0;
      if (done) done_cnt++;
      if (busy) begin
        if (in_exec) begin
          if (sb_q.size() != 0) begin
            e = sb_q[0];
            check_eq("exec_op", alu_op, e.op);
            check_eq("exec_a", alu_a, e.a);
            check_eq("exec_b", alu_b, e.b);
          end
          wb_due  = 1'b1;
          in_exec = 1'b0;
        end else begin
          in_exec = 1'b1;
        end
      end else begin
        in_exec = 1'b0;
      end
    end
  end

  // Compute the expected outcome of an accepted command and queue it.
  task automatic model_cmd(input logic [2:0] op, rd, ra, rb);
    exp_t          e;
    logic [35:0]   r;
    e.op = op; e.a = m_rf[ra]; e.b = m_rf[rb];
    r = alu_model(op, e.a, e.b);
    e.y = r[31:0]; e.f = r[35:32];
    m_rf[rd] = e.y;
    sb_q.push_back(e);
  endtask

  // Offer one command for a cycle; the caller drops cmd_valid afterwards.
  task automatic push_cmd(input logic [2:0] op, rd, ra, rb, input bit exp_ready);
    cmd = {op, rd, ra, rb};
    cmd_valid = 1'b1;
    @(negedge clk);
    check_eq("cmd_ready", cmd_ready, exp_ready);
    if (exp_ready) model_cmd(op, rd, ra, rb);
    @(posedge clk); #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [DW-1:0] d);
    reg_we = 1'b1; reg_waddr = a; reg_wdata = d;
    @(posedge clk); #1;
    reg_we = 1'b0;
    m_rf[a] = d;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [DW-1:0] exp);
    reg_raddr = a;
    #1;
    check_eq(tag, reg_rdata, exp);
  endtask

  task automatic pulse_run();
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    t_issue = cyc;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        t_done = cyc;
        break;
      end
    end
    if (!seen) begin
      check_eq("done_timeout", 64'd0, 64'd1);
      t_done = -1000;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_seen;
    rst_n = 1'b0; cmd = 12'h000; cmd_valid = 1'b0; run = 1'b0;
    reg_we = 1'b0; reg_waddr = 3'd0; reg_wdata = 32'd0; reg_raddr = 3'd0;
    for (int i = 0; i < 8; i++) m_rf[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    check_eq("rst_ready", cmd_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_alu", {alu_op, alu_a, alu_b}, 67'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_flags", {flag_o, flag_c, flag_z, flag_n}, 4'b0000);
    for (int i = 0; i < 8; i++) check_reg("rst_rf", 3'(i), 32'd0);
    @(posedge clk); #1;

    // ADD then SUB chain.
    host_write(3'd1, 32'd5);
    host_write(3'd2, 32'd7);
    push_cmd(ALU_ADD, 3'd3, 3'd1, 3'd2, 1'b1);
    push_cmd(ALU_SUB, 3'd4, 3'd3, 3'd1, 1'b1);
    cmd_valid = 1'b0;
    done_cnt = 0; wb_cnt = 0;
    pulse_run();
    check_eq("run_busy", busy, 1'b1);
    wait_done();
    check_eq("chain_latency", t_done - t_issue, 64'd4);
    check_reg("chain_r3", 3'd3, 32'd12);
    check_reg("chain_r4", 3'd4, 32'd7);
    check_eq("chain_result", result, 32'd7);
    check_eq("chain_z", flag_z, 1'b0);
    check_eq("chain_done", done_cnt, 64'd1);
    check_eq("chain_wb", wb_cnt, 64'd2);

    // SUB to zero.
    host_write(3'd1, 32'd9);
    host_write(3'd2, 32'd9);
    push_cmd(ALU_SUB, 3'd5, 3'd1, 3'd2, 1'b1);
    cmd_valid = 1'b0;
    done_cnt = 0;
    pulse_run();
    wait_done();
    check_eq("zero_latency", t_done - t_issue, 64'd2);
    check_reg("zero_r5", 3'd5, 32'd0);
    check_eq("zero_z", flag_z, 1'b1);
    check_eq("zero_n", flag_n, 1'b0);
    check_eq("zero_done", done_cnt, 64'd1);

    // FIFO full: five back-to-back pushes, the fifth refused.
    host_write(3'd4, 32'd3);
    push_cmd(ALU_XOR, 3'd6, 3'd1, 3'd4, 1'b1);
    push_cmd(ALU_AND, 3'd7, 3'd1, 3'd6, 1'b1);
    push_cmd(ALU_OR,  3'd0, 3'd6, 3'd7, 1'b1);
    push_cmd(ALU_SHL, 3'd5, 3'd2, 3'd4, 1'b1);
    push_cmd(ALU_SUB, 3'd3, 3'd3, 3'd3, 1'b0);
    cmd_valid = 1'b0;
    done_cnt = 0; wb_cnt = 0;
    pulse_run();
    wait_done();
    check_eq("full_wb", wb_cnt, 64'd4);
    check_eq("full_latency", t_done - t_issue, 64'd8);
    check_eq("full_sb_empty", sb_q.size(), 64'd0);
    check_reg("full_r5", 3'd5, 32'd72);

    // Push during run: second command arrives while the first is in EXEC.
    push_cmd(ALU_ADD, 3'd2, 3'd1, 3'd1, 1'b1);
    cmd_valid = 1'b0;
    done_cnt = 0; wb_cnt = 0;
    pulse_run();
    @(posedge clk); #1;
    push_cmd(ALU_SUB, 3'd3, 3'd2, 3'd4, 1'b1);
    cmd_valid = 1'b0;
    wait_done();
    check_eq("dur_wb", wb_cnt, 64'd2);
    check_eq("dur_done", done_cnt, 64'd1);
    check_reg("dur_r3", 3'd3, 32'd15);

    // Host write while busy is dropped; the same write in IDLE lands.
    push_cmd(ALU_ADD, 3'd6, 3'd1, 3'd1, 1'b1);
    cmd_valid = 1'b0;
    pulse_run();
    reg_we = 1'b1; reg_waddr = 3'd1; reg_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    reg_we = 1'b0;
    check_reg("busy_wr_r1", 3'd1, 32'd9);
    wait_done();
    check_reg("busy_wr_r1_after", 3'd1, 32'd9);
    check_reg("busy_wr_r6", 3'd6, 32'd18);
    host_write(3'd1, 32'hFFFF_FFFF);
    check_reg("idle_wr_r1", 3'd1, 32'hFFFF_FFFF);

    // Reset asserted mid-run during EXEC.
    push_cmd(ALU_ADD, 3'd7, 3'd2, 3'd2, 1'b1);
    push_cmd(ALU_ADD, 3'd0, 3'd7, 3'd7, 1'b1);
    cmd_valid = 1'b0;
    done_cnt = 0; wb_cnt = 0;
    pulse_run();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_ready", cmd_ready, 1'b1);
    check_eq("mrst_alu", {alu_op, alu_a, alu_b}, 67'd0);
    for (int i = 0; i < 8; i++) check_reg("mrst_rf", 3'(i), 32'd0);
    sb_q.delete();
    for (int i = 0; i < 8; i++) m_rf[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulse_run();
    busy_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check_eq("mrst_empty_run_busy", busy_seen, 64'd0);
    check_eq("mrst_done", done_cnt, 64'd0);
    check_eq("mrst_wb", wb_cnt, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
